// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions for the instruction/data bus arbiter.
//   htrans_e      : AHB-Lite transfer types
//   HBURST_*      : burst encodings (only SINGLE is generated here)
//   HSIZE_*       : transfer size encodings
//   ahbl_req_t    : captured address-phase request (address plus control)
//   owner_e       : which upstream side owns a bus phase
package ahbl_pkg;

  // Widest address the request bundle can carry; top-level AW must not exceed it.
  localparam int unsigned AHB_AW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef struct packed {
    logic [AHB_AW-1:0] addr;
    logic [2:0]        size;
    logic [3:0]        prot;
    logic              write;
  } ahbl_req_t;

  typedef enum logic {
    OwnImem = 1'b0,
    OwnDmem = 1'b1
  } owner_e;

endpackage

// File: rtl/ahbl_addr_hold.sv
// One-entry holding register for an accepted address phase that could not be
// issued onto the shared bus straight away.
//   clk, rst : clock, synchronous active-high reset
//   capture  : load din and mark the entry valid
//   clear    : entry has been issued; drop valid
//   din      : request to capture
//   valid    : entry holds an unissued request
//   dout     : held request
module ahbl_addr_hold #(
  parameter int unsigned W = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         capture,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (capture) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign dout  = data_q;

endmodule

// File: rtl/ahbl_imem_dmem_arbiter.sv
// Shares one AHB-Lite manager port between the Ibex instruction-side and
// data-side AHB-Lite managers. Uncontended transfers pass straight through;
// a contended address is parked in a per-side holding register and issued
// later, with a bounded streak of wins for the priority side.
//   clk, rst        : clock, synchronous active-high reset
//   imem_*          : instruction-side subordinate port (read-only)
//   dmem_*          : data-side subordinate port
//   bus_*           : shared-bus manager port; bus_hmaster flags the
//                     data-phase owner (0 = instruction, 1 = data)
module ahbl_imem_dmem_arbiter
  import ahbl_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter bit          DATA_FIRST = 1'b1,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] imem_haddr,
  input  logic [1:0]    imem_htrans,
  input  logic [2:0]    imem_hsize,
  input  logic [3:0]    imem_hprot,
  output logic          imem_hready,
  output logic [DW-1:0] imem_hrdata,
  output logic          imem_hresp,
  input  logic [AW-1:0] dmem_haddr,
  input  logic [1:0]    dmem_htrans,
  input  logic [2:0]    dmem_hsize,
  input  logic [3:0]    dmem_hprot,
  input  logic          dmem_hwrite,
  input  logic [DW-1:0] dmem_hwdata,
  output logic          dmem_hready,
  output logic [DW-1:0] dmem_hrdata,
  output logic          dmem_hresp,
  output logic [AW-1:0] bus_haddr,
  output logic [1:0]    bus_htrans,
  output logic [2:0]    bus_hsize,
  output logic [3:0]    bus_hprot,
  output logic          bus_hwrite,
  output logic [DW-1:0] bus_hwdata,
  output logic [2:0]    bus_hburst,
  output logic          bus_hmastlock,
  output logic          bus_hmaster,
  input  logic          bus_hready,
  input  logic [DW-1:0] bus_hrdata,
  input  logic          bus_hresp
);

  localparam int unsigned REQ_W      = $bits(ahbl_req_t);
  localparam logic [3:0]  STREAK_MAX = 4'(MAX_STREAK);
  localparam owner_e      PRIO       = owner_e'(DATA_FIRST);
  localparam owner_e      OTHER      = owner_e'(!DATA_FIRST);

  // Shared state
  logic       dp_v_q, dp_v_d;
  owner_e     dp_own_q, dp_own_d;
  logic [3:0] streak_q, streak_d;
  // While the bus is stalled the address phase on the bus must not change,
  // so the side driving it is remembered until bus_hready returns.
  logic       lock_v_q, lock_v_d;
  owner_e     lock_own_q, lock_own_d;

  // Per-side holding registers
  logic      i_hold_v, d_hold_v;
  ahbl_req_t i_hold_q, d_hold_q;
  logic      i_cap, d_cap, i_clr, d_clr;

  ahbl_req_t i_live, d_live, i_req, d_req, win_req;
  logic      i_hv, d_hv, dp_v, lock_v;
  logic      i_dp, d_dp;
  logic      i_acc, d_acc, i_cand, d_cand, any_cand, other_cand, issue;
  owner_e    win;

  logic unused_htrans;
  assign unused_htrans = imem_htrans[0] ^ dmem_htrans[0];

  // Reset masks live state so outputs read as idle during the reset cycle.
  assign i_hv   = i_hold_v && !rst;
  assign d_hv   = d_hold_v && !rst;
  assign dp_v   = dp_v_q && !rst;
  assign lock_v = lock_v_q && !rst;
  assign i_dp   = dp_v && (dp_own_q == OwnImem);
  assign d_dp   = dp_v && (dp_own_q == OwnDmem);

  // Owner of the data phase is ready when the bus completes it; a side with
  // nothing outstanding is always ready.
  assign imem_hready = i_dp ? bus_hready : !i_hv;
  assign dmem_hready = d_dp ? bus_hready : !d_hv;

  // SEQ is treated as NONSEQ; IDLE/BUSY are ignored.
  assign i_acc = imem_hready && imem_htrans[1] && !rst;
  assign d_acc = dmem_hready && dmem_htrans[1] && !rst;

  assign i_cand   = i_hv || i_acc;
  assign d_cand   = d_hv || d_acc;
  assign any_cand = i_cand || d_cand;
  assign other_cand = DATA_FIRST ? i_cand : d_cand;
  assign issue    = bus_hready && any_cand;

  assign i_live.addr  = AHB_AW'(imem_haddr);
  assign i_live.size  = imem_hsize;
  assign i_live.prot  = imem_hprot;
  assign i_live.write = 1'b0;

  assign d_live.addr  = AHB_AW'(dmem_haddr);
  assign d_live.size  = dmem_hsize;
  assign d_live.prot  = dmem_hprot;
  assign d_live.write = dmem_hwrite;

  assign i_req = i_hv ? i_hold_q : i_live;
  assign d_req = d_hv ? d_hold_q : d_live;

  // Arbitration
  always_comb begin
    win = OwnImem;
    if (lock_v) begin
      win = lock_own_q;
    end else if (i_cand && d_cand) begin
      if (streak_q == STREAK_MAX) begin
        win = OTHER;
      end else begin
        win = PRIO;
      end
    end else if (d_cand) begin
      win = OwnDmem;
    end
  end

  assign win_req = (win == OwnDmem) ? d_req : i_req;

  // Accepted requests that are not issued this cycle go to hold.
  assign i_cap = i_acc && !(issue && (win == OwnImem));
  assign d_cap = d_acc && !(issue && (win == OwnDmem));
  assign i_clr = issue && (win == OwnImem);
  assign d_clr = issue && (win == OwnDmem);

  ahbl_addr_hold #(
    .W(REQ_W)
  ) u_imem_hold (
    .clk    (clk),
    .rst    (rst),
    .capture(i_cap),
    .clear  (i_clr),
    .din    (i_live),
    .valid  (i_hold_v),
    .dout   (i_hold_q)
  );

  ahbl_addr_hold #(
    .W(REQ_W)
  ) u_dmem_hold (
    .clk    (clk),
    .rst    (rst),
    .capture(d_cap),
    .clear  (d_clr),
    .din    (d_live),
    .valid  (d_hold_v),
    .dout   (d_hold_q)
  );

  // Next-state for shared registers
  always_comb begin
    dp_v_d     = dp_v_q;
    dp_own_d   = dp_own_q;
    streak_d   = streak_q;
    lock_v_d   = !bus_hready && any_cand;
    lock_own_d = win;
    if (bus_hready) begin
      dp_v_d = issue;
      if (issue) begin
        dp_own_d = win;
      end
      if (issue && (win == PRIO) && other_cand) begin
        streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_v_q     <= 1'b0;
      dp_own_q   <= OwnImem;
      streak_q   <= '0;
      lock_v_q   <= 1'b0;
      lock_own_q <= OwnImem;
    end else begin
      dp_v_q     <= dp_v_d;
      dp_own_q   <= dp_own_d;
      streak_q   <= streak_d;
      lock_v_q   <= lock_v_d;
      lock_own_q <= lock_own_d;
    end
  end

  // Bus address phase
  always_comb begin
    bus_htrans = IDLE;
    bus_haddr  = '0;
    bus_hsize  = '0;
    bus_hprot  = '0;
    bus_hwrite = 1'b0;
    if (any_cand) begin
      bus_htrans = NONSEQ;
      bus_haddr  = AW'(win_req.addr);
      bus_hsize  = win_req.size;
      bus_hprot  = win_req.prot;
      bus_hwrite = win_req.write;
    end
  end

  assign bus_hburst    = HBURST_SINGLE;
  assign bus_hmastlock = 1'b0;
  assign bus_hmaster   = (dp_own_q == OwnDmem) && !rst;

  // Data phase routing
  assign bus_hwdata  = bus_hmaster ? dmem_hwdata : '0;
  assign imem_hrdata = i_dp ? bus_hrdata : '0;
  assign dmem_hrdata = d_dp ? bus_hrdata : '0;
  assign imem_hresp  = i_dp && bus_hresp;
  assign dmem_hresp  = d_dp && bus_hresp;

endmodule

// File: doc/ahbl_imem_dmem_arbiter.md
Name: ahbl_imem_dmem_arbiter

Overview:
- Shares one AHB-Lite manager port between the Ibex instruction-side and data-side AHB-Lite managers, which are the outputs of the Ibex-to-AHB-Lite bridge.
- Places the core on a single-port system bus: unified SRAM plus peripherals.
- Each upstream side may have at most one accepted transfer outstanding. An uncontended transfer passes through with zero added latency.
- A contended address is captured in a per-side holding register and issued later, with a programmable anti-starvation limit.

Parameters:
AW, 32, address width
DW, 32, data width
DATA_FIRST, 1, 1: data side has priority on contention; 0: instruction side has priority
MAX_STREAK, 4, maximum consecutive grants to the priority side while the other side waits (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_haddr  in  AW  instruction-side address
imem_htrans  in  2  instruction-side transfer type
imem_hsize  in  3  instruction-side size
imem_hprot  in  4  instruction-side protection
imem_hready  out  1  instruction-side ready
imem_hrdata  out  DW  instruction-side read data
imem_hresp  out  1  instruction-side error
dmem_haddr  in  AW  data-side address
dmem_htrans  in  2  data-side transfer type
dmem_hsize  in  3  data-side size
dmem_hprot  in  4  data-side protection
dmem_hwrite  in  1  data-side write
dmem_hwdata  in  DW  data-side write data
dmem_hready  out  1  data-side ready
dmem_hrdata  out  DW  data-side read data
dmem_hresp  out  1  data-side error
bus_haddr  out  AW  shared-bus address
bus_htrans  out  2  shared-bus transfer type
bus_hsize  out  3  shared-bus size
bus_hprot  out  4  shared-bus protection
bus_hwrite  out  1  shared-bus write
bus_hwdata  out  DW  shared-bus write data
bus_hburst  out  3  constant SINGLE (0)
bus_hmastlock  out  1  constant 0
bus_hmaster  out  1  data-phase owner (0 = instruction, 1 = data)
bus_hready  in  1  shared-bus ready
bus_hrdata  in  DW  shared-bus read data
bus_hresp  in  1  shared-bus error

Behaviour:
- Request definition: a side is requesting when htrans[1]=1. SEQ is treated as NONSEQ. IDLE and BUSY are ignored. The instruction side is read-only, so its bus_hwrite is 0.
- Per-side state:
  - hold_v plus the captured address/control (accepted but not yet issued).
  - out_v: transfer in the bus data phase.
- Shared state:
  - dp_v and dp_own: data phase active, and its owner.
  - streak: a 4-bit counter.
- Side ready:
  - x_hready = 1 when the side has no accepted transfer outstanding (hold_v=0 and not the data-phase owner).
  - Otherwise x_hready = 1 in the cycle when dp_v and dp_own=x and bus_hready=1.
  - Else x_hready = 0.
- Acceptance: a side's address is accepted when x_hready=1 and it is requesting. An accepted address must go either straight onto the bus (bypass) or into hold.
- Bus address phase, evaluated when bus_hready=1:
  - Candidates per side: hold_v, or a live accepted request (bypass).
  - Only one candidate: it wins.
  - Both: the priority side wins, except when streak=MAX_STREAK, in which case the other side wins.
  - Winner: drives bus_htrans=NONSEQ and its address/control. Next cycle dp_v=1, dp_own=winner, and the winner's hold_v is cleared if it was issued from hold.
  - Loser with a live accepted request: captured into hold.
- When bus_hready=0: bus address/control are held stable and nothing is issued.
- No candidate: bus_htrans=IDLE, bus_haddr=0.
- streak:
  - Increments, saturating at MAX_STREAK, when the priority side wins while the other side has a candidate.
  - Clears when the non-priority side wins or has no candidate.
- Data phase:
  - bus_hwdata = dmem_hwdata whenever dp_own=1, else 0.
  - Read data is routed to the owner; the non-owner gets hrdata=0.
  - bus_hresp is routed to the owner in both cycles of the two-cycle error response; the non-owner gets hresp=0.
  - On the final data-phase cycle (bus_hready=1), dp_v drops unless a new issue occurs in the same cycle.
- Error on a transfer: it does not cancel the other side's held transfer; that transfer issues normally.
- Simultaneous events: a side completing its data phase and presenting a new address in the same cycle has that address accepted (x_hready=1). The new address bypasses or is held under the normal rules.
- Reset (synchronous, rst=1): clears hold_v, dp_v and streak.
  - Outputs: bus_htrans=IDLE, bus_haddr=0, bus_hwrite=0, bus_hmaster=0, both x_hready=1, hresp=0, hrdata=0.
  - Reset mid-transfer abandons that transfer; the whole bus shares this reset.
- Latency:
  - Uncontended: identical to a direct connection.
  - A held transfer adds one cycle per transfer issued ahead of it.

Decomposition:
- Package ahbl_pkg:
  - htrans_e: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
  - HBURST_SINGLE and HSIZE_BYTE/HALF/WORD constants.
  - ahbl_req_t struct: addr, size, prot, write.
- Sub-module ahbl_addr_hold: a one-entry holding register (capture, valid, release), instantiated once per side.

Test Plan:
- Solo instruction fetches, imem_haddr 0x0000_0100, bus_hready=1, read data 0xDEAD_BEEF → bus_haddr 0x100 in the same cycle, imem_hrdata=0xDEAD_BEEF next cycle, no stalls, bus_hmaster=0.
- Simultaneous NONSEQ, imem 0x200 and dmem 0x8000_0000 write 0x1234_5678, DATA_FIRST=1 → data issued first; instruction address held; bus_haddr 0x200 one cycle later; imem_hready low one extra cycle; bus_hwdata=0x1234_5678 in the data-side data phase.
- Both sides requesting continuously, MAX_STREAK=4 → data side wins 4 times, instruction side wins the 5th slot, then the streak restarts.
- Slave wait states, bus_hready low for 3 cycles during a data read → bus address stable, dmem_hready low for 3 cycles, held imem transfer not issued until bus_hready returns.
- Error response, bus_hresp=1 with bus_hready 0 then 1 on a data transfer → dmem_hresp=1 for both cycles, imem_hresp=0, the held instruction transfer then completes normally.
- rst asserted while a held transfer and an active data phase exist → next cycle bus_htrans=IDLE, both x_hready=1, hold_v=0, streak=0.
